mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/rr_pick2.sv | 23 ++
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port read arbiter.
// State encodings and port indices used by mem_arbiter.
package mem_arb_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way winner pick: round-robin or port-0 priority.
// Purely combinational; ties resolved by last_grant or fixed_prio.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic       winner,
  output logic       any
);

  // Tie goes to port 0 under priority, else away from last winner.
  always_comb begin
    any    = |req;
    winner = PORT0;
    if (req == 2'b11)
      winner = fixed_prio ? PORT0 : ~last_grant;
    else if (req[1])
      winner = PORT1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port read arbiter in front of a single-port memory.
// IDLE -> ISSUE -> RESP, with direct RESP -> ISSUE handoff.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rstrb,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rstrb_q, rstrb_d;
  logic [1:0]        elig;
  logic              win, any;

  // Requests that may win this edge; the served port is consumed.
  always_comb begin
    elig = 2'b00;
    if (state_q == S_IDLE)
      elig = {p1_req, p0_req};
    else if (state_q == S_RESP)
      elig = grant_q ? {1'b0, p0_req} : {p1_req, 1'b0};
  end

  rr_pick2 u_pick (
    .req        (elig),
    .last_grant (last_q),
    .fixed_prio (FIXED_PRIO != 0),
    .winner     (win),
    .any        (any)
  );

  // Next-state: grant from IDLE or RESP, strobe only on grant.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    rstrb_d = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (any) begin
          state_d = S_ISSUE;
          grant_d = win;
          last_d  = win;
          addr_d  = win ? p1_addr : p0_addr;
          rstrb_d = 1'b1;
        end
      end
      S_ISSUE: state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // State and memory-side registers; reset aborts any access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= PORT0;
      last_q  <= PORT1;
      addr_q  <= '0;
      rstrb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      rstrb_q <= rstrb_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rstrb = rstrb_q;
  assign busy      = (state_q != S_IDLE);
  assign p0_rvalid = (state_q == S_RESP) && (grant_q == PORT0);
  assign p1_rvalid = (state_q == S_RESP) && (grant_q == PORT1);
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter, round-robin and priority builds.
// Both instances share requests; each has its own memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req = 1'b0, p1_req = 1'b0;
  logic [31:0] p0_addr = '0, p1_addr = '0;

  logic        r_p0v, r_p1v, r_rstrb, r_busy;
  logic [31:0] r_rdata, r_maddr, r_mdata;
  logic        f_p0v, f_p1v, f_rstrb, f_busy;
  logic [31:0] f_rdata, f_maddr, f_mdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:2] == 30'd4) return 32'h0015_0513;
    return 32'hA500_0000 ^ a;
  endfunction

  always @(posedge clk) if (r_rstrb) r_mdata <= mem_word(r_maddr);
  always @(posedge clk) if (f_rstrb) f_mdata <= mem_word(f_maddr);

  mem_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_rvalid(r_p0v),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_rvalid(r_p1v),
    .rdata(r_rdata), .mem_addr(r_maddr), .mem_rstrb(r_rstrb),
    .mem_rdata(r_mdata), .busy(r_busy)
  );

  mem_arbiter #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_rvalid(f_p0v),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_rvalid(f_p1v),
    .rdata(f_rdata), .mem_addr(f_maddr), .mem_rstrb(f_rstrb),
    .mem_rdata(f_mdata), .busy(f_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    r_mdata = '0;
    f_mdata = '0;
    #2;
    chk("rst_busy", {31'd0, r_busy}, 0);
    chk("rst_rstrb", {31'd0, r_rstrb}, 0);
    chk("rst_addr", r_maddr, 0);
    chk("rst_rv", {30'd0, r_p1v, r_p0v}, 0);
    tick;
    reset = 1'b0;

    // single p0 read
    p0_req = 1'b1; p0_addr = 32'h10;
    tick;
    chk("s_rstrb", {31'd0, r_rstrb}, 1);
    chk("s_addr", r_maddr, 32'h10);
    chk("s_rv_early", {31'd0, r_p0v}, 0);
    tick;
    chk("s_rstrb_off", {31'd0, r_rstrb}, 0);
    chk("s_rv", {30'd0, r_p1v, r_p0v}, 2'b01);
    chk("s_rdata", r_rdata, 32'h0015_0513);
    p0_req = 1'b0;
    tick;
    chk("s_idle", {30'd0, r_busy, r_p0v}, 0);

    // tie right after reset: p0 first, p1 by handoff
    reset = 1'b1; #1; reset = 1'b0;
    p0_req = 1'b1; p0_addr = 32'h20;
    p1_req = 1'b1; p1_addr = 32'h40;
    tick;
    chk("t_addr0", r_maddr, 32'h20);
    tick;
    chk("t_rv0", {30'd0, r_p1v, r_p0v}, 2'b01);
    chk("t_rd0", r_rdata, 32'hA500_0020);
    p0_req = 1'b0;
    tick;
    chk("t_handoff", {30'd0, r_busy, r_rstrb}, 2'b11);
    chk("t_addr1", r_maddr, 32'h40);
    chk("t_rv_gap", {30'd0, r_p1v, r_p0v}, 0);
    tick;
    chk("t_rv1", {30'd0, r_p1v, r_p0v}, 2'b10);
    chk("t_rd1", r_rdata, 32'hA500_0040);
    p1_req = 1'b0;
    tick;
    chk("t_idle", {31'd0, r_busy}, 0);

    // both held for 8 accesses: alternate starting at p0
    p0_req = 1'b1; p0_addr = 32'h100;
    p1_req = 1'b1; p1_addr = 32'h204;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("rr_addr", r_maddr, (i % 2 == 0) ? 32'h100 : 32'h204);
      chk("rr_strb", {31'd0, r_rstrb}, 1);
      tick;
      chk("rr_rv", {30'd0, r_p1v, r_p0v},
          (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_rd", r_rdata,
          (i % 2 == 0) ? 32'hA500_0100 : 32'hA500_0204);
      if (i == 7) begin
        p0_req = 1'b0;
        p1_req = 1'b0;
      end
    end
    tick;
    chk("rr_idle", {31'd0, r_busy}, 0);

    // p0 alone, then tie: rr picks p1, fixed picks p0
    p0_req = 1'b1; p0_addr = 32'h30;
    tick;
    tick;
    chk("fp_pre_rv", {31'd0, f_p0v}, 1);
    p0_req = 1'b0;
    tick;
    p0_req = 1'b1; p0_addr = 32'h50;
    p1_req = 1'b1; p1_addr = 32'h60;
    tick;
    chk("fp_rr_addr", r_maddr, 32'h60);
    chk("fp_fp_addr", f_maddr, 32'h50);
    tick;
    chk("fp_rr_rv", {30'd0, r_p1v, r_p0v}, 2'b10);
    chk("fp_fp_rv", {30'd0, f_p1v, f_p0v}, 2'b01);
    chk("fp_fp_rd", f_rdata, 32'hA500_0050);
    tick;
    chk("fp_rr_addr2", r_maddr, 32'h50);
    chk("fp_fp_addr2", f_maddr, 32'h60);
    tick;
    chk("fp_fp_rv2", {30'd0, f_p1v, f_p0v}, 2'b10);
    chk("fp_fp_rd2", f_rdata, 32'hA500_0060);
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick;
    chk("fp_idle", {30'd0, f_busy, r_busy}, 0);

    // reset during ISSUE aborts; tie rule restored
    p1_req = 1'b1; p1_addr = 32'h70;
    tick;
    chk("ra_strb", {31'd0, r_rstrb}, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("ra_async", {30'd0, r_busy, r_rstrb}, 0);
    chk("ra_addr", r_maddr, 0);
    tick;
    chk("ra_norv", {30'd0, r_p1v, r_p0v}, 0);
    reset = 1'b0;
    p0_req = 1'b1; p0_addr = 32'h80;
    tick;
    chk("ra_tie", r_maddr, 32'h80);
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick;
    chk("ra_rv", {30'd0, r_p1v, r_p0v}, 2'b01);
    tick;
    tick;
    chk("ra_idle", {31'd0, r_busy}, 0);

    // back-to-back p0, req held one cycle past rvalid
    for (int k = 0; k < 2; k++) begin
      p0_req = 1'b1; p0_addr = 32'h90;
      tick;
      chk("bb_strb", {31'd0, r_rstrb}, 1);
      tick;
      chk("bb_rv", {31'd0, r_p0v}, 1);
      tick;
      chk("bb_nodup", {29'd0, r_busy, r_rstrb, r_p0v}, 0);
      p0_req = 1'b0;
      tick;
      chk("bb_idle", {30'd0, r_busy, r_rstrb}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
